sar_seq_ctrl: RTL and testbench

- Parametrised successor to the single-channel SAR ADC logic in the user project.
- Sequences multi-channel successive-approximation conversions with generic resolution.
- Adds per-channel oversampling/averaging, single or continuous scan, and a valid/ready result port with overrun detection.
- Sits between the analog comparator/DAC macro (via io pads) and the digital result consumer, clocked by wb_clk_i.

---
 rtl/sar_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sar_seq_ctrl
//
// Purpose:
//   Sequencer for a multi-channel successive-approximation ADC. For each
//   channel selected in a latched mask it runs a sample phase and a
//   bit-by-bit binary search against an external comparator/DAC macro. It
//   optionally averages 2^avg conversions per channel and hands each
//   averaged result to a consumer through a one-entry valid/ready holding
//   register. A result that arrives while the holding register is still
//   full is dropped and flagged on a sticky overrun output. Scans are either
//   single-shot or continuous.
//
// Parameters:
//   RES           conversion resolution in bits (2..16)
//   NCH           number of analog channels (1..16)
//   SAMPLE_CYC    sample-phase length in clocks (>= 1)
//   AVG_MAX_LOG2  largest accepted log2 of the averaging count
//
// Ports:
//   wb_clk_i     in   system clock
//   wb_rst_i     in   asynchronous active-high reset
//   start_i      in   pulse; starts a scan when idle and the mask is nonzero
//   cont_i       in   continuous scan; looked at after the last channel
//   ch_mask_i    in   channels to scan, latched at start
//   avg_sel_i    in   log2 averages per channel, latched at start, clamped
//   clr_ovr_i    in   clears overrun_o (a same-cycle drop takes priority)
//   comp_i       in   comparator, pre-synchronised; 1 means Vin >= Vdac
//   sample_o     out  sample switch enable
//   dac_code_o   out  trial code for the capacitive DAC
//   ch_sel_o     out  analog mux select
//   busy_o       out  high whenever the sequencer is not idle
//   res_valid_o  out  holding register full
//   res_ready_i  in   consumer accepts the held result
//   res_data_o   out  averaged result
//   res_ch_o     out  channel that produced res_data_o
//   overrun_o    out  sticky; a result was dropped
// ---------------------------------------------------------------------------
module sar_seq_ctrl #(
    parameter  int RES          = 10,
    parameter  int NCH          = 4,
    parameter  int SAMPLE_CYC   = 4,
    parameter  int AVG_MAX_LOG2 = 3,
    localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    input  logic            cont_i,
    input  logic [NCH-1:0]  ch_mask_i,
    input  logic [2:0]      avg_sel_i,
    input  logic            clr_ovr_i,
    input  logic            comp_i,
    output logic            sample_o,
    output logic [RES-1:0]  dac_code_o,
    output logic [CH_W-1:0] ch_sel_o,
    output logic            busy_o,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [RES-1:0]  res_data_o,
    output logic [CH_W-1:0] res_ch_o,
    output logic            overrun_o
);

    // avg_sel_i is only three bits wide, so the usable limit never exceeds 7.
    localparam int         AVG_LIM_I = (AVG_MAX_LOG2 > 7) ? 7 : AVG_MAX_LOG2;
    localparam logic [2:0] AVG_LIM   = 3'(AVG_LIM_I);
    localparam int         ACC_W     = RES + AVG_LIM_I;
    // One extra bit so the count can reach 2^avg itself.
    localparam int         CNT_W     = AVG_LIM_I + 1;
    localparam int         BI_W      = $clog2(RES);
    localparam int         SC_W      = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        ACCUM,
        NEXT
    } state_t;

    state_t state_q;
    state_t state_d;

    // Scan configuration, captured at start.
    logic [NCH-1:0]   mask_q;
    logic [2:0]       avg_q;
    logic [CH_W-1:0]  cur_ch_q;

    // Conversion datapath.
    logic [SC_W-1:0]  samp_cnt_q;
    logic [BI_W-1:0]  bit_idx_q;
    logic [RES-1:0]   code_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] avg_cnt_q;
    logic [RES-1:0]   result_q;

    // Result holding register.
    logic             res_valid_q;
    logic [RES-1:0]   res_data_q;
    logic [CH_W-1:0]  res_ch_q;
    logic             overrun_q;

    // Combinational helpers.
    logic             start_ok;
    logic [2:0]       avg_clamped;
    logic             samp_last;
    logic             bit_last;
    logic [RES-1:0]   trial_code;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_shift;
    logic [CNT_W-1:0] cnt_inc;
    logic             avg_done;
    logic             hi_found;
    logic [CH_W-1:0]  hi_ch;
    logic [CH_W-1:0]  wrap_ch;
    logic             res_load;
    logic             res_drop;

    // Index of the lowest set bit of a channel mask (0 for an empty mask).
    function automatic logic [CH_W-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = CH_W'(i);
            end
        end
        return r;
    endfunction

    assign start_ok    = start_i && (|ch_mask_i);
    assign avg_clamped = (avg_sel_i > AVG_LIM) ? AVG_LIM : avg_sel_i;
    assign samp_last   = (samp_cnt_q == SC_W'(SAMPLE_CYC - 1));
    assign bit_last    = (bit_idx_q == '0);

    // Trial code: bits already decided, the bit under test forced to 1,
    // everything below it still 0 (code_q is cleared before each conversion
    // and only ever gains bits at or above the current index).
    assign trial_code  = code_q | (RES'(1) << bit_idx_q);

    assign acc_sum     = acc_q + ACC_W'(code_q);
    assign acc_shift   = acc_sum >> avg_q;
    assign cnt_inc     = avg_cnt_q + CNT_W'(1);
    assign avg_done    = (cnt_inc >= (CNT_W'(1) << avg_q));
    assign wrap_ch     = lowest_set(mask_q);

    // Next set mask bit strictly above the current channel. Scanning from the
    // top down leaves the closest one in hi_ch.
    always_comb begin
        // NOTE: every variable written here gets a value before any condition,
        // otherwise the untaken paths would infer latches.
        hi_found = 1'b0;
        hi_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_ch_q))) begin
                hi_found = 1'b1;
                hi_ch    = CH_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register and next-state logic.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok)  state_d = SAMPLE;
            SAMPLE:  if (samp_last) state_d = CONVERT;
            CONVERT: if (bit_last)  state_d = ACCUM;
            ACCUM:   state_d = avg_done ? NEXT : SAMPLE;
            // A higher channel remains, or the scan wraps in continuous mode.
            NEXT:    state_d = (hi_found || cont_i) ? SAMPLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Conversion datapath.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mask_q     <= '0;
            avg_q      <= '0;
            cur_ch_q   <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= BI_W'(RES - 1);
            code_q     <= '0;
            acc_q      <= '0;
            avg_cnt_q  <= '0;
            result_q   <= '0;
        end else begin
            // Phase counters rest at their start value outside their phase,
            // so each phase begins cleanly without explicit set-up.
            samp_cnt_q <= (state_q == SAMPLE && !samp_last) ? samp_cnt_q + SC_W'(1) : '0;
            bit_idx_q  <= (state_q == CONVERT) ? bit_idx_q - BI_W'(1) : BI_W'(RES - 1);

            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        mask_q   <= ch_mask_i;
                        avg_q    <= avg_clamped;
                        cur_ch_q <= lowest_set(ch_mask_i);
                    end
                end
                SAMPLE: begin
                    code_q <= '0;
                end
                CONVERT: begin
                    // Keep the trial bit when Vin is at or above the DAC level.
                    if (comp_i) begin
                        code_q <= trial_code;
                    end
                end
                ACCUM: begin
                    if (avg_done) begin
                        result_q  <= acc_shift[RES-1:0];
                        acc_q     <= '0;
                        avg_cnt_q <= '0;
                    end else begin
                        acc_q     <= acc_sum;
                        avg_cnt_q <= cnt_inc;
                    end
                end
                NEXT: begin
                    cur_ch_q <= hi_found ? hi_ch : wrap_ch;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Result holding register and overrun flag.
    // The register can be refilled in the same cycle its old content is
    // taken, so a full register never blocks a consumer that is ready.
    // -----------------------------------------------------------------------
    assign res_load = (state_q == NEXT) && (!res_valid_q || res_ready_i);
    assign res_drop = (state_q == NEXT) && !res_load;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
        end else if (res_load) begin
            res_valid_q <= 1'b1;
            res_data_q  <= result_q;
            res_ch_q    <= cur_ch_q;
        end else if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set, so no loss
    // can go unreported.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overrun_q <= 1'b0;
        end else if (res_drop) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr_i) begin
            overrun_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign sample_o    = (state_q == SAMPLE);
    assign dac_code_o  = (state_q == CONVERT) ? trial_code : '0;
    assign ch_sel_o    = cur_ch_q;
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_ch_o    = res_ch_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_seq_ctrl
//
// Directed bench for sar_seq_ctrl (RES=10, NCH=4, SAMPLE_CYC=4,
// AVG_MAX_LOG2=3). An ideal comparator drives comp_i from a per-channel
// input voltage table; optionally the voltage alternates by +3 LSB between
// successive conversions. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_sar_seq_ctrl;

    localparam int RES          = 10;
    localparam int NCH          = 4;
    localparam int SAMPLE_CYC   = 4;
    localparam int AVG_MAX_LOG2 = 3;
    localparam int CH_W         = 2;
    // Cycles from start to res_valid_o for one conversion, and per extra one.
    localparam int LAT0         = SAMPLE_CYC + RES + 3;
    localparam int LAT_EXTRA    = SAMPLE_CYC + RES + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cont;
    logic [NCH-1:0]  ch_mask;
    logic [2:0]      avg_sel;
    logic            clr_ovr;
    logic            comp;
    logic            sample;
    logic [RES-1:0]  dac_code;
    logic [CH_W-1:0] ch_sel;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [RES-1:0]  res_data;
    logic [CH_W-1:0] res_ch;
    logic            overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int t0;
    int base_conv;

    // Comparator model state.
    logic [RES-1:0] vin_tab [NCH];
    logic           alt_mode;
    int             alt_base;
    int             conv_n = 0;
    logic [RES-1:0] vin_eff;

    always #5 clk = ~clk;

    sar_seq_ctrl #(
        .RES          (RES),
        .NCH          (NCH),
        .SAMPLE_CYC   (SAMPLE_CYC),
        .AVG_MAX_LOG2 (AVG_MAX_LOG2)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start),
        .cont_i      (cont),
        .ch_mask_i   (ch_mask),
        .avg_sel_i   (avg_sel),
        .clr_ovr_i   (clr_ovr),
        .comp_i      (comp),
        .sample_o    (sample),
        .dac_code_o  (dac_code),
        .ch_sel_o    (ch_sel),
        .busy_o      (busy),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_ch_o    (res_ch),
        .overrun_o   (overrun)
    );

    // Each sample phase starts a new conversion.
    always @(posedge sample) conv_n++;

    // Ideal comparator: Vin >= Vdac.
    always_comb begin
        vin_eff = vin_tab[ch_sel];
        if (alt_mode && (((conv_n - alt_base) % 2) == 0)) begin
            vin_eff = vin_eff + 10'd3;
        end
        comp = (vin_eff >= dac_code);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_cnt++;
        end
    endtask

    // Pulse start for one cycle; t0 marks the start cycle.
    task automatic start_scan(input logic [NCH-1:0] m, input logic [2:0] a);
        start   = 1'b1;
        ch_mask = m;
        avg_sel = a;
        t0      = cyc_cnt;
        cyc(1);
        start   = 1'b0;
        ch_mask = '0;
        avg_sel = '0;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int i = 0; i < max_cyc && res_valid !== 1'b1; i++) cyc(1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_sample"},   32'(sample),    32'd0);
        check({pfx, "_dac"},      32'(dac_code),  32'd0);
        check({pfx, "_ch_sel"},   32'(ch_sel),    32'd0);
        check({pfx, "_busy"},     32'(busy),      32'd0);
        check({pfx, "_valid"},    32'(res_valid), 32'd0);
        check({pfx, "_data"},     32'(res_data),  32'd0);
        check({pfx, "_res_ch"},   32'(res_ch),    32'd0);
        check({pfx, "_overrun"},  32'(overrun),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        ch_mask   = '0;
        avg_sel   = '0;
        clr_ovr   = 1'b0;
        res_ready = 1'b0;
        alt_mode  = 1'b0;
        alt_base  = 0;
        for (int i = 0; i < NCH; i++) vin_tab[i] = '0;

        // ---- reset state ----
        cyc(2);
        check_all_zero("reset");
        rst = 1'b0;
        cyc(1);

        // ---- single conversion, vin=0x2A5, avg=0 ----
        vin_tab[0] = 10'h2A5;
        start_scan(4'b0001, 3'd0);                 // now at T+1
        check("t1_sample_first", 32'(sample),   32'd1);
        check("t1_dac_in_sample", 32'(dac_code), 32'd0);
        check("t1_busy",          32'(busy),     32'd1);
        cyc(3);                                    // T+4
        check("t1_sample_last",   32'(sample),   32'd1);
        cyc(1);                                    // T+5
        check("t1_sample_end",    32'(sample),   32'd0);
        check("t1_dac_b9",        32'(dac_code), 32'h200);
        cyc(1);
        check("t1_dac_b8",        32'(dac_code), 32'h300);
        cyc(1);
        check("t1_dac_b7",        32'(dac_code), 32'h280);
        cyc(1);
        check("t1_dac_b6",        32'(dac_code), 32'h2C0);
        wait_valid(30);
        check("t1_valid",         32'(res_valid), 32'd1);
        check("t1_latency",       32'(cyc_cnt - t0), 32'(LAT0));
        check("t1_data",          32'(res_data), 32'h2A5);
        check("t1_ch",            32'(res_ch),   32'd0);
        check("t1_busy_fell",     32'(busy),     32'd0);
        cyc(3);                                    // held while not ready
        check("t1_hold_valid",    32'(res_valid), 32'd1);
        check("t1_hold_data",     32'(res_data), 32'h2A5);
        res_ready = 1'b1;
        cyc(1);
        check("t1_taken",         32'(res_valid), 32'd0);

        // ---- extremes: vin=0 on ch0, vin=0x3FF on ch1 ----
        vin_tab[0] = 10'h000;
        vin_tab[1] = 10'h3FF;
        start_scan(4'b0011, 3'd0);
        wait_valid(30);
        check("ext_lo_ch",        32'(res_ch),   32'd0);
        check("ext_lo_data",      32'(res_data), 32'h000);
        cyc(1);
        wait_valid(30);
        check("ext_hi_ch",        32'(res_ch),   32'd1);
        check("ext_hi_data",      32'(res_data), 32'h3FF);
        check("ext_busy",         32'(busy),     32'd0);
        check("ext_overrun",      32'(overrun),  32'd0);
        cyc(1);

        // ---- averaging: avg=2, vin alternates 0x100/0x103, start ignored when busy ----
        vin_tab[0] = 10'h100;
        vin_tab[3] = 10'h3C0;
        alt_mode   = 1'b1;
        alt_base   = conv_n;
        start_scan(4'b0001, 3'd2);
        cyc(20);
        start   = 1'b1;                            // must be ignored
        ch_mask = 4'b1000;
        cyc(1);
        start   = 1'b0;
        ch_mask = '0;
        wait_valid(120);
        check("avg_valid",        32'(res_valid), 32'd1);
        check("avg_data",         32'(res_data), 32'h101);
        check("avg_ch",           32'(res_ch),   32'd0);
        check("avg_samples",      32'(conv_n - alt_base), 32'd4);
        check("avg_latency",      32'(cyc_cnt - t0), 32'(LAT0 + 3 * LAT_EXTRA));
        alt_mode = 1'b0;
        cyc(1);

        // ---- averaging clamp: avg_sel=7 behaves as 3 (8 conversions) ----
        vin_tab[2] = 10'h155;
        base_conv  = conv_n;
        start_scan(4'b0100, 3'd7);
        wait_valid(200);
        check("clamp_data",       32'(res_data), 32'h155);
        check("clamp_ch",         32'(res_ch),   32'd2);
        check("clamp_samples",    32'(conv_n - base_conv), 32'd8);
        check("clamp_latency",    32'(cyc_cnt - t0), 32'(LAT0 + 7 * LAT_EXTRA));
        cyc(1);

        // ---- continuous scan over ch1/ch3 ----
        vin_tab[1] = 10'h0C3;
        vin_tab[3] = 10'h3A0;
        cont = 1'b1;
        start_scan(4'b1010, 3'd0);
        for (int r = 0; r < 4; r++) begin
            wait_valid(40);
            check("cont_ch",   32'(res_ch),   (r % 2 == 0) ? 32'd1 : 32'd3);
            check("cont_data", 32'(res_data), (r % 2 == 0) ? 32'h0C3 : 32'h3A0);
            cyc(1);
        end
        cont = 1'b0;                               // scan in progress on ch1 ends after ch3
        wait_valid(40);
        check("stop_ch1",         32'(res_ch),   32'd1);
        check("stop_busy_mid",    32'(busy),     32'd1);
        cyc(1);
        wait_valid(40);
        check("stop_ch3",         32'(res_ch),   32'd3);
        check("stop_busy_fell",   32'(busy),     32'd0);
        check("stop_overrun",     32'(overrun),  32'd0);
        cyc(2);
        check("stop_idle",        32'(busy),     32'd0);

        // ---- overrun: consumer stalled over two results ----
        res_ready  = 1'b0;
        vin_tab[0] = 10'h0AA;
        vin_tab[1] = 10'h1F0;
        start_scan(4'b0011, 3'd0);
        wait_valid(40);
        check("ovr_first_data",   32'(res_data), 32'h0AA);
        check("ovr_first_clear",  32'(overrun),  32'd0);
        for (int i = 0; i < 40 && busy === 1'b1; i++) cyc(1);
        check("ovr_scan_done",    32'(busy),     32'd0);
        check("ovr_held_valid",   32'(res_valid), 32'd1);
        check("ovr_held_data",    32'(res_data), 32'h0AA);
        check("ovr_held_ch",      32'(res_ch),   32'd0);
        check("ovr_set",          32'(overrun),  32'd1);
        clr_ovr = 1'b1;
        cyc(1);
        clr_ovr = 1'b0;
        check("ovr_cleared",      32'(overrun),  32'd0);

        // Drop and clear in the same cycle (NEXT is cycle T+16).
        start_scan(4'b0010, 3'd0);                 // T+1
        cyc(15);                                   // T+16
        check("ovr_pre_simul",    32'(overrun),  32'd0);
        clr_ovr = 1'b1;
        cyc(1);
        clr_ovr = 1'b0;
        check("ovr_simul_set",    32'(overrun),  32'd1);
        check("ovr_simul_data",   32'(res_data), 32'h0AA);

        // ---- reset pulsed mid-CONVERT ----
        vin_tab[2] = 10'h2A5;
        start_scan(4'b0100, 3'd0);
        cyc(7);                                    // T+8, converting
        check("rst_pre_busy",     32'(busy),     32'd1);
        check("rst_pre_sample",   32'(sample),   32'd0);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        cyc(1);
        rst = 1'b0;
        cyc(1);
        res_ready = 1'b1;
        start_scan(4'b0100, 3'd0);
        wait_valid(30);
        check("post_rst_latency", 32'(cyc_cnt - t0), 32'(LAT0));
        check("post_rst_data",    32'(res_data), 32'h2A5);
        check("post_rst_ch",      32'(res_ch),   32'd2);
        check("post_rst_ovr",     32'(overrun),  32'd0);
        cyc(1);

        // ---- start with empty mask is ignored ----
        start_scan(4'b0000, 3'd0);
        check("empty_busy",       32'(busy),     32'd0);
        cyc(3);
        check("empty_busy_later", 32'(busy),     32'd0);
        check("empty_sample",     32'(sample),   32'd0);
        check("empty_valid",      32'(res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
